// File: rtl/mem_io_bridge.sv
// mem_io_bridge: CPU data-port bridge splitting the address space into a
// synchronous RAM region and a memory-mapped I/O region starting at IO_BASE.
//
// I/O map (offsets from IO_BASE):
//   0 GPIO_OUT    r/w
//   1 GPIO_IN     r    (gpio_in through a 2-flop synchronizer)
//   2 FIFO_STATUS r    bit0 empty, bit1 full, bits[4:2] count
//   3 FIFO_DATA   r    load pops the input FIFO
//   4 TIMER       r/w  free-running counter      (MEM_IO_TIMER_EN only)
//   5 TIMER_CMP   r/w  compare value             (MEM_IO_TIMER_EN only)
//   6 TIMER_FLAG  r/w1c bit0 match flag          (MEM_IO_TIMER_EN only)
//   7+            read 0, writes ignored
//
// Configuration macro: MEM_IO_TIMER_EN -- when undefined, offsets 4-6 read 0,
// writes to them are ignored and no timer state exists.
//
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   mem_address, data_to_mem_store, write_to_memory, reading_for_load
//                                 CPU request
//   data_from_mem                 read data, one cycle after the address
//   ram_addr, ram_wdata, ram_we, ram_rdata
//                                 synchronous RAM, 1-cycle read latency
//   gpio_in, gpio_out             general-purpose I/O
//   in_valid, in_data, in_ready   producer side of the input FIFO
module mem_io_bridge #(
   parameter int unsigned      WIDTH      = 16,
   parameter logic [WIDTH-1:0] IO_BASE    = 16'hFF00,
   parameter int unsigned      FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] mem_address,
   input  logic [WIDTH-1:0] data_to_mem_store,
   input  logic             write_to_memory,
   input  logic             reading_for_load,
   output logic [WIDTH-1:0] data_from_mem,
   output logic [WIDTH-1:0] ram_addr,
   output logic [WIDTH-1:0] ram_wdata,
   output logic             ram_we,
   input  logic [WIDTH-1:0] ram_rdata,
   input  logic [WIDTH-1:0] gpio_in,
   output logic [WIDTH-1:0] gpio_out,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

   localparam logic [WIDTH-1:0] OFF_GPIO_OUT    = WIDTH'(0);
   localparam logic [WIDTH-1:0] OFF_GPIO_IN     = WIDTH'(1);
   localparam logic [WIDTH-1:0] OFF_FIFO_STATUS = WIDTH'(2);
   localparam logic [WIDTH-1:0] OFF_FIFO_DATA   = WIDTH'(3);
   localparam logic [WIDTH-1:0] OFF_TIMER       = WIDTH'(4);
   localparam logic [WIDTH-1:0] OFF_TIMER_CMP   = WIDTH'(5);
   localparam logic [WIDTH-1:0] OFF_TIMER_FLAG  = WIDTH'(6);

   typedef enum logic {SEL_RAM, SEL_IO} region_e;

   // ---------------------------------------------------------------- decode
   logic             io_region;
   logic [WIDTH-1:0] io_off;
   logic             io_wr;

   assign io_region = (mem_address >= IO_BASE);
   assign io_off    = mem_address - IO_BASE;
   assign io_wr     = write_to_memory && io_region;

   assign ram_addr  = mem_address;
   assign ram_wdata = data_to_mem_store;
   assign ram_we    = write_to_memory && !io_region;

   // ---------------------------------------------------------------- FIFO
   logic [WIDTH-1:0] fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    count;
   logic             empty, full, push, pop;
   logic [2:0]       count3;

   assign empty    = (count == '0);
   assign full     = (count == CW'(FIFO_DEPTH));
   // Held low during reset so no word is taken while state is being cleared.
   assign in_ready = !full && !reset;
   assign push     = in_valid && in_ready;
   assign pop      = reading_for_load && io_region && (io_off == OFF_FIFO_DATA) && !empty;
   assign count3   = 3'(count);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= in_data;
   end

   // ---------------------------------------------------------------- GPIO
   logic [WIDTH-1:0] sync1, sync2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gpio_out <= '0;
         sync1    <= '0;
         sync2    <= '0;
      end else begin
         sync1 <= gpio_in;
         sync2 <= sync1;
         if (io_wr && io_off == OFF_GPIO_OUT) gpio_out <= data_to_mem_store;
      end
   end

   // ---------------------------------------------------------------- timer
   logic [WIDTH-1:0] timer_rd, cmp_rd, flag_rd;

`ifdef MEM_IO_TIMER_EN
   logic [WIDTH-1:0] timer_q, cmp_q;
   logic             flag_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timer_q <= '0;
         cmp_q   <= '1;
         flag_q  <= 1'b0;
      end else begin
         if (io_wr && io_off == OFF_TIMER) timer_q <= data_to_mem_store;
         else                              timer_q <= timer_q + WIDTH'(1);
         if (io_wr && io_off == OFF_TIMER_CMP) cmp_q <= data_to_mem_store;
         // Set has priority over a same-cycle write-1-to-clear.
         if (timer_q == cmp_q)
            flag_q <= 1'b1;
         else if (io_wr && io_off == OFF_TIMER_FLAG && data_to_mem_store[0])
            flag_q <= 1'b0;
      end
   end

   assign timer_rd = timer_q;
   assign cmp_rd   = cmp_q;
   assign flag_rd  = {{(WIDTH-1){1'b0}}, flag_q};
`else
   assign timer_rd = '0;
   assign cmp_rd   = '0;
   assign flag_rd  = '0;
`endif

   // ---------------------------------------------------------------- read path
   logic [WIDTH-1:0] fifo_status;
   logic [WIDTH-1:0] io_rd;
   logic [WIDTH-1:0] io_rdata_q;
   region_e          region_q;
   logic             live_q;

   always_comb begin
      fifo_status      = '0;
      fifo_status[0]   = empty;
      fifo_status[1]   = full;
      fifo_status[4:2] = count3;
   end

   always_comb begin
      io_rd = '0;
      case (io_off)
         OFF_GPIO_OUT:    io_rd = gpio_out;
         OFF_GPIO_IN:     io_rd = sync2;
         OFF_FIFO_STATUS: io_rd = fifo_status;
         OFF_FIFO_DATA:   if (!empty) io_rd = fifo_mem[rd_ptr];
         OFF_TIMER:       io_rd = timer_rd;
         OFF_TIMER_CMP:   io_rd = cmp_rd;
         OFF_TIMER_FLAG:  io_rd = flag_rd;
         default:         io_rd = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         io_rdata_q <= '0;
         region_q   <= SEL_RAM;
         live_q     <= 1'b0;
      end else begin
         io_rdata_q <= io_rd;
         region_q   <= io_region ? SEL_IO : SEL_RAM;
         live_q     <= 1'b1;
      end
   end

   // live_q masks the RAM's unreset read port so the output is 0 from reset
   // until the first address has been captured.
   assign data_from_mem = !live_q ? '0 :
                          (region_q == SEL_IO) ? io_rdata_q : ram_rdata;

endmodule
